// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit with HI/LO result registers.
// Latency: WIDTH+1 edges from accept to done (1 edge for divide by zero). Does not
// queue: start is ignored while busy. A start presented in the done cycle is accepted.
//
// Ports:
//   Clock, reset        - clock and synchronous active-high reset
//   start, op, a, b     - operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_wr, lo_wr, wdata - direct HI/LO writes, honoured only in IDLE without start
//   hi, lo              - registered HI/LO results
//   busy, done          - operation in flight / one-cycle result-write pulse
//   div_zero            - the last completed operation was a divide by zero
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;   // product / quotient must be negated
  logic             neg_r;   // remainder takes the sign of a
  logic             bz;      // divide by zero captured at accept
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc;     // product high half / partial remainder
  logic [WIDTH-1:0] sh;      // product low half / multiplier / quotient bits

  // Operand conditioning at accept time. Only the signed ops (op[0]==0) take
  // magnitudes; the most negative value maps onto itself, which is the correct
  // unsigned magnitude.
  logic             sgn_in;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    sgn_in = ~op[0];
    a_neg  = sgn_in & a[WIDTH-1];
    b_neg  = sgn_in & b[WIDTH-1];
    b_zero = (b == '0);
    a_mag  = a_neg ? (~a + 1'b1) : a;
    b_mag  = b_neg ? (~b + 1'b1) : b;
  end

  // One iteration of each algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    // Multiply: add multiplicand into the high half when the current
    // multiplier bit is set, then shift {carry, acc, sh} right by one.
    mul_sum  = {1'b0, acc} + (sh[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    // Restoring divide: bring the next dividend bit into the remainder and
    // keep the subtraction only when it does not underflow.
    div_sh   = {acc, sh[WIDTH-1]};
    div_diff = div_sh - {1'b0, mag_b};
    div_ge   = ~div_diff[WIDTH];
    prod     = {acc, sh};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    quot_fix = neg_q ? (~sh + 1'b1) : sh;
    rem_fix  = neg_r ? (~acc + 1'b1) : acc;
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (op[1] && b_zero) ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state == CALC) || (state == FIX);
  end

  // Datapath and result registers.
  always_ff @(posedge Clock) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      bz       <= 1'b0;
      mag_b    <= '0;
      acc      <= '0;
      sh       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            bz     <= op[1] & b_zero;
            mag_b  <= b_mag;
            acc    <= '0;
            // Divide by zero skips CALC; keep the raw dividend for hi.
            sh     <= (op[1] && b_zero) ? a : a_mag;
            cnt    <= CW'(WIDTH);
          end else begin
            if (hi_wr) hi <= wdata;
            if (lo_wr) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            sh  <= {sh[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            sh  <= {mul_sum[0], sh[WIDTH-1:1]};
          end
        end
        FIX: begin
          done     <= 1'b1;
          div_zero <= bz;
          if (bz) begin
            hi <= sh;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
